// File: rtl/count_frame_sender.sv
// Serial UART 8N1 sender of a snapshot of count channels: sync bytes AA 55, then channel data MSB first.
// Define COUNT_FRAME_CHECKSUM_EN to append a mod-256 sum of the data bytes.
module count_frame_sender #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 4_000_000,
    parameter int NUM_CH    = 9,
    parameter int COUNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*COUNT_W-1:0] counts,
    input  logic                      send,
    output logic                      busy,
    output logic [5:0]                ch_sel,
    output logic                      frame_done,
    output logic                      tx
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int BPC = (COUNT_W + 7) / 8;
    localparam int EW  = BPC * 8;
    localparam int ND  = NUM_CH * BPC;
`ifdef COUNT_FRAME_CHECKSUM_EN
    localparam int NBYTES = ND + 3;
`else
    localparam int NBYTES = ND + 2;
`endif
    localparam int TW = $clog2(DIV);
    localparam int CW = $clog2(NBYTES + 1);
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                    state;
    logic [TW-1:0]             timer;
    logic [2:0]                bit_idx;
    logic [CW-1:0]             byte_cnt;
    logic [7:0]                shreg;
    logic [5:0]                ch_cnt;
    logic [PW-1:0]             pos_cnt;
    logic [NUM_CH*COUNT_W-1:0] snap;
`ifdef COUNT_FRAME_CHECKSUM_EN
    logic [7:0]                csum;
`endif

    logic [7:0]    data_bytes [ND];
    logic [CW-1:0] nb;
    logic [IW-1:0] didx;
    logic [7:0]    next_byte;
    logic          is_data;
    logic          tick;
    logic          last_byte;
    logic          accept;

    // Snapshot laid out in transmit order: per channel, zero-extended, MSB first
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [EW-1:0] ext;
        assign ext = EW'(snap[c*COUNT_W +: COUNT_W]);
        for (genvar p = 0; p < BPC; p++) begin : g_pos
            assign data_bytes[c*BPC+p] = ext[(BPC-1-p)*8 +: 8];
        end
    end

    assign tick      = (timer == TW'(DIV - 1));
    assign nb        = byte_cnt + CW'(1);
    assign didx      = IW'(nb - CW'(2));
    assign is_data   = (nb >= CW'(2)) && (nb < CW'(ND + 2));
    assign last_byte = (byte_cnt == CW'(NBYTES - 1));
    // A frame may start on the very edge the previous one finishes
    assign accept    = send && ((state == IDLE) ||
                                ((state == STOP) && tick && last_byte));

    always_comb begin
        next_byte = 8'h55;
        if (is_data) begin
            next_byte = data_bytes[didx];
        end
`ifdef COUNT_FRAME_CHECKSUM_EN
        else if (nb != CW'(1)) begin
            next_byte = csum;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            ch_cnt     <= '0;
            pos_cnt    <= '0;
            snap       <= '0;
            busy       <= 1'b0;
            ch_sel     <= '0;
            frame_done <= 1'b0;
            tx         <= 1'b1;
`ifdef COUNT_FRAME_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            frame_done <= (state == STOP) && tick && last_byte;
            if (state != IDLE) begin
                timer <= tick ? '0 : timer + TW'(1);
            end
            if (accept) begin
                state    <= START;
                timer    <= '0;
                byte_cnt <= '0;
                shreg    <= 8'hAA;
                snap     <= counts;
                ch_cnt   <= '0;
                pos_cnt  <= '0;
                busy     <= 1'b1;
                ch_sel   <= '0;
                tx       <= 1'b0;
`ifdef COUNT_FRAME_CHECKSUM_EN
                csum     <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        timer <= '0;
                    end
                    START: begin
                        if (tick) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            tx      <= shreg[0];
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                tx      <= shreg[1];
                                shreg   <= shreg >> 1;
                            end
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            if (last_byte) begin
                                state  <= IDLE;
                                busy   <= 1'b0;
                                ch_sel <= '0;
                            end else begin
                                state    <= START;
                                tx       <= 1'b0;
                                byte_cnt <= nb;
                                shreg    <= next_byte;
                                ch_sel   <= is_data ? ch_cnt : 6'd0;
                                if (is_data) begin
                                    if (pos_cnt == PW'(BPC - 1)) begin
                                        pos_cnt <= '0;
                                        ch_cnt  <= ch_cnt + 6'd1;
                                    end else begin
                                        pos_cnt <= pos_cnt + PW'(1);
                                    end
`ifdef COUNT_FRAME_CHECKSUM_EN
                                    csum <= csum + next_byte;
`endif
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_frame_sender.sv
// Randomized scoreboard bench for count_frame_sender: UART decoder monitor vs frame model.
module tb_count_frame_sender;

    localparam int NUM_CH  = 3;
    localparam int COUNT_W = 12;
    localparam int DIV     = 25;
    localparam int BPC     = (COUNT_W + 7) / 8;
`ifdef COUNT_FRAME_CHECKSUM_EN
    localparam int NBYTES  = 2 + NUM_CH * BPC + 1;
`else
    localparam int NBYTES  = 2 + NUM_CH * BPC;
`endif
    localparam int FRAME_CLKS = NBYTES * 10 * DIV;

    typedef struct {
        int b;
        int ch;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      send = 1'b0;
    logic [NUM_CH*COUNT_W-1:0] counts = '0;
    logic                      busy;
    logic [5:0]                ch_sel;
    logic                      frame_done;
    logic                      tx;

    count_frame_sender #(
        .CLK_FREQ (100_000_000),
        .BAUD_RATE(4_000_000),
        .NUM_CH   (NUM_CH),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .counts    (counts),
        .send      (send),
        .busy      (busy),
        .ch_sel    (ch_sel),
        .frame_done(frame_done),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   model_end = 0;
    int   done_cnt = 0;
    bit   model_busy = 1'b0;
    exp_t exp_q[$];
    int   done_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NUM_CH*COUNT_W-1:0] rand_counts();
        logic [NUM_CH*COUNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_CH; k++) c[k*COUNT_W +: COUNT_W] = COUNT_W'($urandom);
        return c;
    endfunction

    // Expected frame: sync, each channel MSB-first zero-extended, optional byte sum
    function automatic void push_frame(input logic [NUM_CH*COUNT_W-1:0] c);
        int sum;
        int v;
        int by;
        sum = 0;
        exp_q.push_back('{b: 'hAA, ch: 0});
        exp_q.push_back('{b: 'h55, ch: 0});
        for (int k = 0; k < NUM_CH; k++) begin
            v = int'(c[k*COUNT_W +: COUNT_W]);
            for (int p = BPC - 1; p >= 0; p--) begin
                by = (v >> (8 * p)) & 255;
                sum += by;
                exp_q.push_back('{b: by, ch: k});
            end
        end
`ifdef COUNT_FRAME_CHECKSUM_EN
        exp_q.push_back('{b: sum & 255, ch: 0});
`endif
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            model_busy = 1'b0;
            exp_q.delete();
            done_q.delete();
        end else if (send && (!model_busy || cyc == model_end)) begin
            push_frame(counts);
            model_busy = 1'b1;
            model_end  = cyc + FRAME_CLKS;
            done_q.push_back(model_end);
        end else if (model_busy && cyc == model_end) begin
            model_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", int'(busy), int'(model_busy));
            if (!model_busy) check("ch_sel_idle", int'(ch_sel), 0);
            if (frame_done) begin
                done_cnt++;
                if (done_q.size() == 0) check("frame_done_unexpected", 1, 0);
                else check("frame_done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic waitn(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (reset) ab = 1'b1;
        end
    endtask

    initial begin : decoder
        bit         ab;
        logic [7:0] d;
        int         st;
        int         sp;
        int         cs;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                ab = 1'b0;
                d  = '0;
                waitn(DIV / 2, ab);
                st = int'(tx);
                cs = int'(ch_sel);
                for (int b = 0; b < 8; b++) begin
                    waitn(DIV, ab);
                    d[b] = tx;
                end
                waitn(DIV, ab);
                sp = int'(tx);
                if (!ab) begin
                    if (exp_q.size() == 0) begin
                        check("byte_unexpected", int'(d), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", int'(d), e.b);
                        check("ch_sel", cs, e.ch);
                        check("start_bit", st, 0);
                        check("stop_bit", sp, 1);
                    end
                end
            end
        end
    end

    task automatic pulse_send();
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic noise_sends();
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(50, 300)) @(negedge clk);
            counts = rand_counts();
            send = 1'b1;
            @(negedge clk);
            send = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (!model_busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, int'(ok), 1);
        repeat (10) @(negedge clk);
    endtask

    initial begin : driver
        int d0;
        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ch_sel", int'(ch_sel), 0);
        check("reset_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        counts = {12'hABC, 12'h123, 12'hFFF};
        pulse_send();
        noise_sends();
        wait_idle("idle_directed");

        counts = '0;
        pulse_send();
        wait_idle("idle_zeros");
        counts = '1;
        pulse_send();
        wait_idle("idle_ones");

        for (int f = 0; f < 6; f++) begin
            counts = rand_counts();
            repeat ($urandom_range(0, 40)) @(negedge clk);
            pulse_send();
            if (f % 2 == 1) noise_sends();
            wait_idle("idle_random");
        end

        @(negedge clk);
        send = 1'b1;
        for (int i = 0; i < 3 * FRAME_CLKS / 100; i++) begin
            counts = rand_counts();
            repeat (100) @(negedge clk);
        end
        send = 1'b0;
        wait_idle("idle_back_to_back");

        counts = rand_counts();
        pulse_send();
        repeat (400) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_tx", int'(tx), 1);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_ch_sel", int'(ch_sel), 0);
        check("async_reset_frame_done", int'(frame_done), 0);
        d0 = done_cnt;
        @(negedge clk);
        @(negedge clk);
        #3 reset = 1'b0;
        repeat (FRAME_CLKS) @(negedge clk);
        check("no_done_after_reset", done_cnt, d0);

        counts = rand_counts();
        pulse_send();
        wait_idle("idle_after_reset");

        check("bytes_outstanding", exp_q.size(), 0);
        check("done_outstanding", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
